clk_div_prog: RTL

- Multi-channel, runtime-programmable clock divider for the audio capture path.
- Generates several 50%-duty divided clocks from the 50 MHz system clock, e.g. 2 Hz frame select and audio bit and sample clocks.
- Each channel also produces a one-cycle rising-edge tick, so downstream logic can stay on the system clock.
- Divisors can be changed glitch-free at runtime, and a sync input re-aligns all channels.

---
 rtl/clk_div_prog.sv | 103 ++++++++++
 1 files changed

// File: rtl/clk_div_prog.sv
// Multi-channel programmable 50%-duty clock divider with rising-edge ticks.
// Optional per-channel rising-edge counters: define CLK_DIV_PROG_EDGE_CNT_EN.
module clk_div_prog #(
    parameter int          NUM_CH   = 2,
    parameter int          CNT_W    = 24,
    parameter int unsigned DEF_HALF = 12499999
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       en,
    input  logic [NUM_CH*CNT_W-1:0] div_half,
    input  logic [NUM_CH-1:0]       load,
    input  logic                    sync,
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       tick
`ifdef CLK_DIV_PROG_EDGE_CNT_EN
    ,
    output logic [NUM_CH*16-1:0]    edge_cnt
`endif
);

    localparam logic [CNT_W-1:0] DEF_H = CNT_W'(DEF_HALF);

    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [CNT_W-1:0]  act_q [NUM_CH];
    logic [CNT_W-1:0]  act_d [NUM_CH];
    logic [CNT_W-1:0]  shd_q [NUM_CH];
    logic [CNT_W-1:0]  shd_d [NUM_CH];
    logic [NUM_CH-1:0] clk_q, clk_d;
    logic [NUM_CH-1:0] tick_q, tick_d;

    always_comb begin
        clk_d  = clk_q;
        tick_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            act_d[i] = act_q[i];
            shd_d[i] = load[i] ? div_half[i*CNT_W +: CNT_W] : shd_q[i];
            if (sync) begin
                // A same-cycle load goes straight into the active half period.
                cnt_d[i] = '0;
                clk_d[i] = 1'b1;
                act_d[i] = shd_d[i];
            end else if (en[i]) begin
                if (cnt_q[i] == act_q[i]) begin
                    cnt_d[i]  = '0;
                    clk_d[i]  = ~clk_q[i];
                    tick_d[i] = ~clk_q[i];
                    act_d[i]  = shd_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_q  <= '1;
            tick_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
                act_q[i] <= DEF_H;
                shd_q[i] <= DEF_H;
            end
        end else begin
            clk_q  <= clk_d;
            tick_q <= tick_d;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
                act_q[i] <= act_d[i];
                shd_q[i] <= shd_d[i];
            end
        end
    end

    assign clk_out = clk_q;
    assign tick    = tick_q;

`ifdef CLK_DIV_PROG_EDGE_CNT_EN
    // Counts update on the same edge that raises tick, so they include it.
    logic [15:0] ecnt_q [NUM_CH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (rst || sync) begin
                ecnt_q[i] <= '0;
            end else if (tick_d[i]) begin
                ecnt_q[i] <= ecnt_q[i] + 16'd1;
            end
        end
    end

    always_comb begin
        edge_cnt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            edge_cnt[i*16 +: 16] = ecnt_q[i];
        end
    end
`endif

endmodule
